puf_reader: RTL and testbench
=============================

# puf_reader

Sequencing controller that drives an arbiter PUF's challenge and launch inputs and collects its response bits. It generates per-bit challenges from a seeded LFSR, resets and fires the race once per evaluation, synchronizes the latched response, and majority-votes repeated evaluations. It delivers a RESP_BITS-wide response word over a valid/ready handshake. It sits between the arbiter PUF instance and the key-derivation logic.

## Interface
- CHAL_W, 32: challenge width driven to the PUF. Fixed at 32.
- RESP_BITS, 32: response bits per run. Legal range 1..64.
- SETTLE_CYCLES, 4: settle time per phase. Must be ≥1.
- VOTES, 5: evaluations per bit. Odd, ≥1.

- clk_i  in  1  single clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  start request; accepted only in IDLE
- seed_i  in  32  LFSR seed, sampled with accepted start
- busy_o  out  1  high from accepted start until handshake completes
- resp_valid_o  out  1  response word available
- resp_ready_i  in  1  consumer accepts word
- resp_data_o  out  RESP_BITS  response word; bit k = k-th generated bit
- puf_switch_o  out  2  race launch pair to PUF (00 = latch reset, 11 = fire)
- puf_challenge_o  out  CHAL_W  challenge to PUF
- puf_resp_i  in  1  asynchronous latch output from PUF

## Operation
- States: IDLE, ARM, FIRE, DONE.
- IDLE
  - On start_i, latch seed_i into the LFSR. A zero seed is replaced by 32'h0000_0001.
  - Clear bit index, vote counters and resp_data_o; go to ARM.
- ARM
  - puf_switch_o=00 and puf_challenge_o=LFSR state, held for SETTLE_CYCLES cycles; then go to FIRE.
- FIRE
  - puf_switch_o=11 for SETTLE_CYCLES+2 cycles; the challenge is held.
  - On the last FIRE cycle, sample stage 2 of a 2-flop synchronizer on puf_resp_i. If 1, increment ones_cnt (width $clog2(VOTES+1)).
  - Increment eval_cnt. If eval_cnt < VOTES, return to ARM.
  - Otherwise, write resp_data_o[bit_idx] = (ones_cnt > VOTES/2), clear both counters, and advance the LFSR once.
  - If bit_idx = RESP_BITS-1, go to DONE; else increment bit_idx and go to ARM.
- LFSR: Galois, next = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 0). Bit 0 uses the seed itself.
- DONE
  - resp_valid_o=1; resp_data_o is stable. puf_switch_o=00, puf_challenge_o=0.
  - On resp_valid_o & resp_ready_i, go to IDLE.
- Boundaries
  - start_i in ARM, FIRE or DONE is ignored, including start coincident with ready in DONE.
  - rst_i at any time forces IDLE and all outputs to reset values; a partial word is discarded.
  - In IDLE, puf_challenge_o=0 and puf_switch_o=00.

## Timing
- Reset values: busy_o=0, resp_valid_o=0, resp_data_o=0, puf_switch_o=00, puf_challenge_o=0; synchronizer flops cleared to 0.
- Evaluation length E = 2·SETTLE_CYCLES+2 cycles. Per bit = VOTES·E cycles.
- Start accepted at edge N:
  - busy_o=1 from N+1.
  - First ARM cycle is N+1.
  - resp_valid_o rises at N+1+RESP_BITS·VOTES·E.
  - Defaults give N+1601.
- Handshake at edge M: resp_valid_o=0 and busy_o=0 from M+1. A new start is accepted no earlier than M+1.
- puf_challenge_o changes only on an ARM entry that follows a completed bit, never during FIRE.

## Test plan
- Reset values: hold rst_i for 3 cycles, then release -> all outputs at reset values, state IDLE; start_i held low -> no change.
- Basic run: RESP_BITS=4, VOTES=1, SETTLE_CYCLES=1, seed 32'h1, PUF model returns challenge[0].
  - Challenges must be 0x00000001, 0x80200003, 0xC0300002, 0x60180001.
  - resp_data_o=4'hB; resp_valid_o rises 17 cycles after start.
  - puf_switch_o per evaluation: 00 for 1 cycle, then 11 for 3 cycles.
- Zero seed: same configuration with seed 0 -> identical challenge sequence and resp_data_o=4'hB.
- Voting: VOTES=5, model returns 1 on 3 of 5 evaluations for bit 0 and on 2 of 5 for bit 1 -> resp_data_o[0]=1, resp_data_o[1]=0.
- Backpressure: hold resp_ready_i low for 10 cycles in DONE and pulse start_i.
  - resp_data_o stable, start_i ignored.
  - Raise resp_ready_i -> resp_valid_o and busy_o low the next cycle.
- Reset mid-run: assert rst_i during FIRE of bit 2 -> next cycle all outputs at reset values; a new start runs a full-length run from the new seed.

Source files
------------

// File: rtl/puf_reader_if.sv
// puf_reader_if: control and response handshake between puf_reader and its consumer
// Signals: start/seed request a run, busy reports a run in progress,
// resp_valid/resp_ready/resp_data carry the finished response word.
// Modports: master drives requests and ready, slave (puf_reader) drives status and data.
interface puf_reader_if #(
    parameter int RESP_BITS = 32
);
    logic                 start;
    logic [31:0]          seed;
    logic                 busy;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [RESP_BITS-1:0] resp_data;

    modport master (output start, seed, resp_ready, input busy, resp_valid, resp_data);
    modport slave  (input start, seed, resp_ready, output busy, resp_valid, resp_data);
endinterface

// File: rtl/puf_reader.sv
// puf_reader: sequences an arbiter PUF, majority-votes each response bit and returns a word
// Ports: clk_i/rst_i clock and synchronous active-high reset; bus (slave) start/seed/busy
// and the resp_valid/resp_ready/resp_data handshake; puf_switch_o launch pair
// (00 latch reset, 11 fire); puf_challenge_o challenge; puf_resp_i asynchronous latch output.
module puf_reader #(
    parameter int CHAL_W        = 32,
    parameter int RESP_BITS     = 32,
    parameter int SETTLE_CYCLES = 4,
    parameter int VOTES         = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    puf_reader_if.slave       bus,
    output logic [1:0]        puf_switch_o,
    output logic [CHAL_W-1:0] puf_challenge_o,
    input  logic              puf_resp_i
);
    localparam int CW = $clog2(SETTLE_CYCLES + 2);
    localparam int VW = $clog2(VOTES + 1);
    localparam int BW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    typedef enum logic [1:0] {IDLE, ARM, FIRE, DONE} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [VW-1:0]        ones, ones_n, evals, evals_n;
    logic [BW-1:0]        bit_idx, bit_idx_n;
    logic [31:0]          lfsr, lfsr_n;
    logic [RESP_BITS-1:0] data, data_n;
    logic [1:0]           sync;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            ones    <= '0;
            evals   <= '0;
            bit_idx <= '0;
            lfsr    <= '0;
            data    <= '0;
            sync    <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ones    <= ones_n;
            evals   <= evals_n;
            bit_idx <= bit_idx_n;
            lfsr    <= lfsr_n;
            data    <= data_n;
            sync    <= {sync[0], puf_resp_i};
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ones_n    = ones;
        evals_n   = evals;
        bit_idx_n = bit_idx;
        lfsr_n    = lfsr;
        data_n    = data;
        case (state)
            IDLE: if (bus.start) begin
                lfsr_n    = (bus.seed == 32'h0) ? 32'h1 : bus.seed;
                cnt_n     = '0;
                ones_n    = '0;
                evals_n   = '0;
                bit_idx_n = '0;
                data_n    = '0;
                state_n   = ARM;
            end
            ARM: if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                cnt_n   = '0;
                state_n = FIRE;
            end else cnt_n = cnt + CW'(1);
            FIRE: if (cnt == CW'(SETTLE_CYCLES + 1)) begin
                // the extra two FIRE cycles let the race result cross both synchronizer stages
                cnt_n   = '0;
                ones_n  = ones + VW'(sync[1]);
                evals_n = evals + VW'(1);
                state_n = ARM;
                if (evals_n == VW'(VOTES)) begin
                    data_n[bit_idx] = ones_n > VW'(VOTES / 2);
                    ones_n  = '0;
                    evals_n = '0;
                    lfsr_n  = (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
                    if (bit_idx == BW'(RESP_BITS - 1)) state_n = DONE;
                    else bit_idx_n = bit_idx + BW'(1);
                end
            end else cnt_n = cnt + CW'(1);
            DONE: if (bus.resp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.busy        = state != IDLE;
    assign bus.resp_valid  = state == DONE;
    assign bus.resp_data   = data;
    assign puf_switch_o    = (state == FIRE) ? 2'b11 : 2'b00;
    assign puf_challenge_o = (state == ARM || state == FIRE) ? CHAL_W'(lfsr) : '0;
endmodule

// File: tb/tb_puf_reader.sv
// tb_puf_reader: directed scoreboard bench for puf_reader (two configurations)
module tb_puf_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  sw_a, sw_b;
    logic [31:0] ch_a, ch_b;
    logic        pr_a, pr_b;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ev_b = 0;
    logic [1:0]  prev_b = 2'b00;
    logic [10:0] pat_b = 11'b01001101010;
    logic [31:0] chal_q[$];
    logic [63:0] res_q[$];

    always #5 clk = ~clk;

    puf_reader_if #(.RESP_BITS(4)) ia ();
    puf_reader_if #(.RESP_BITS(2)) ib ();

    puf_reader #(.RESP_BITS(4), .SETTLE_CYCLES(1), .VOTES(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .bus(ia),
        .puf_switch_o(sw_a), .puf_challenge_o(ch_a), .puf_resp_i(pr_a)
    );

    puf_reader #(.RESP_BITS(2), .SETTLE_CYCLES(4), .VOTES(5)) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(ib),
        .puf_switch_o(sw_b), .puf_challenge_o(ch_b), .puf_resp_i(pr_b)
    );

    // PUF A answers with challenge bit 0; PUF B follows a per-evaluation pattern
    assign pr_a = (sw_a == 2'b11) & ch_a[0];
    assign pr_b = (sw_b == 2'b11) & pat_b[ev_b];

    always @(negedge clk) begin
        prev_b <= sw_b;
        if (sw_b == 2'b11 && prev_b != 2'b11 && ev_b < 10) ev_b <= ev_b + 1;
    end

    function automatic logic [31:0] nxt(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset;
        chk("rst_busy", 64'(ia.busy), 64'(0));
        chk("rst_valid", 64'(ia.resp_valid), 64'(0));
        chk("rst_data", 64'(ia.resp_data), 64'(0));
        chk("rst_switch", 64'(sw_a), 64'(0));
        chk("rst_chal", 64'(ch_a), 64'(0));
    endtask

    task automatic run_a(input logic [31:0] seed, input bit bp);
        logic [31:0] s, cur;
        logic [3:0]  w;
        logic [63:0] e;
        s = (seed == 32'h0) ? 32'h1 : seed;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            chal_q.push_back(s);
            w[k] = s[0];
            s = nxt(s);
        end
        res_q.push_back(64'(w));
        ia.seed = seed;
        ia.start = 1'b1;
        tick;
        ia.start = 1'b0;
        cur = '0;
        for (int t = 1; t <= 17; t++) begin
            if (t < 17) begin
                if ((t - 1) % 4 == 0) cur = chal_q.pop_front();
                chk("chal", 64'(ch_a), 64'(cur));
                chk("switch", 64'(sw_a), ((t - 1) % 4 == 0) ? 64'(0) : 64'(3));
                chk("busy", 64'(ia.busy), 64'(1));
            end
            chk("valid", 64'(ia.resp_valid), 64'(t == 17));
            if (t < 17) tick;
        end
        e = res_q.pop_front();
        chk("data", 64'(ia.resp_data), e);
        chk("done_switch", 64'(sw_a), 64'(0));
        chk("done_chal", 64'(ch_a), 64'(0));
        if (bp) begin
            for (int i = 0; i < 10; i++) begin
                ia.start = (i == 3);
                ia.seed = 32'h5;
                tick;
                chk("bp_valid", 64'(ia.resp_valid), 64'(1));
                chk("bp_data", 64'(ia.resp_data), e);
                chk("bp_busy", 64'(ia.busy), 64'(1));
            end
        end
        ia.resp_ready = 1'b1;
        ia.start = bp;
        tick;
        ia.resp_ready = 1'b0;
        ia.start = 1'b0;
        chk("hs_valid", 64'(ia.resp_valid), 64'(0));
        chk("hs_busy", 64'(ia.busy), 64'(0));
        tick;
        chk("idle_busy", 64'(ia.busy), 64'(0));
    endtask

    initial begin
        int t;
        logic [63:0] e;
        ia.start = 1'b0; ia.seed = '0; ia.resp_ready = 1'b0;
        ib.start = 1'b0; ib.seed = '0; ib.resp_ready = 1'b0;
        repeat (3) tick;
        rst = 1'b0;
        tick;
        chk_reset;
        chk("rst_b_busy", 64'(ib.busy), 64'(0));
        repeat (3) tick;
        chk("idle_hold_busy", 64'(ia.busy), 64'(0));
        chk("idle_hold_chal", 64'(ch_a), 64'(0));

        run_a(32'h1, 1'b0);
        run_a(32'h0, 1'b0);
        run_a(32'h1357_9BDF, 1'b1);

        res_q.push_back(64'(2'b01));
        ib.seed = 32'h1234;
        ib.start = 1'b1;
        tick;
        ib.start = 1'b0;
        t = 1;
        while (!ib.resp_valid && t < 200) begin
            tick;
            t++;
        end
        chk("b_latency", 64'(t), 64'(101));
        e = res_q.pop_front();
        chk("b_data", 64'(ib.resp_data), e);
        ib.resp_ready = 1'b1;
        tick;
        ib.resp_ready = 1'b0;
        chk("b_hs_valid", 64'(ib.resp_valid), 64'(0));

        ia.seed = 32'hDEAD_BEEF;
        ia.start = 1'b1;
        tick;
        ia.start = 1'b0;
        repeat (10) tick;
        chk("mid_fire", 64'(sw_a), 64'(3));
        rst = 1'b1;
        tick;
        chk_reset;
        rst = 1'b0;
        run_a(32'h0BAD_F00D, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
